// File: rtl/maxpool_frame_buffer.sv
// Ping-pong frame buffer behind the max-pool stage: one bank fills while the
// other is read combinationally; bank ownership is tracked and overflow flagged.
module maxpool_frame_buffer #(
  parameter int datwidth   = 16,
  parameter int outputsize = 55,
  parameter int addrwidth  = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [datwidth-1:0] i_data,
  input  logic                i_data_valid,
  output logic                o_wr_ready,
  output logic                o_overflow,
  input  logic [31:0]         address,
  output logic [datwidth-1:0] o_data,
  output logic                o_frame_ready,
  input  logic                i_frame_release,
  output logic [7:0]          o_frame_count
);

  localparam int FRAME = outputsize * outputsize;
  localparam int IW    = (FRAME > 1) ? $clog2(FRAME) : 1;

  logic [datwidth-1:0]  mem [2][FRAME];

  logic                 wr_bank_q, wr_bank_d;
  logic                 rd_bank_q, rd_bank_d;
  logic [1:0]           bank_full_q, bank_full_d;
  logic [addrwidth-1:0] wr_cnt_q, wr_cnt_d;
  logic                 overflow_q, overflow_d;
  logic [7:0]           frame_count_q, frame_count_d;

  logic accept;
  logic last_pixel;
  logic release_ok;
  logic in_range;

  assign accept     = i_data_valid && !bank_full_q[wr_bank_q];
  assign last_pixel = accept && (wr_cnt_q == addrwidth'(FRAME - 1));
  assign release_ok = i_frame_release && bank_full_q[rd_bank_q];
  assign in_range   = address < 32'(FRAME);

  // Completion and release always touch different bank bits, so both apply.
  always_comb begin
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    bank_full_d   = bank_full_q;
    wr_cnt_d      = wr_cnt_q;
    overflow_d    = overflow_q;
    frame_count_d = frame_count_q;
    if (accept) begin
      if (last_pixel) begin
        wr_cnt_d               = '0;
        bank_full_d[wr_bank_q] = 1'b1;
        wr_bank_d              = ~wr_bank_q;
        frame_count_d          = frame_count_q + 8'd1;
      end else begin
        wr_cnt_d = wr_cnt_q + addrwidth'(1);
      end
    end
    if (i_data_valid && !accept) begin
      overflow_d = 1'b1;
    end
    if (release_ok) begin
      bank_full_d[rd_bank_q] = 1'b0;
      rd_bank_d              = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      bank_full_q   <= 2'b00;
      wr_cnt_q      <= '0;
      overflow_q    <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      bank_full_q   <= bank_full_d;
      wr_cnt_q      <= wr_cnt_d;
      overflow_q    <= overflow_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Pixel storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (rst && accept) begin
      mem[wr_bank_q][wr_cnt_q[IW-1:0]] <= i_data;
    end
  end

  assign o_wr_ready    = !bank_full_q[wr_bank_q];
  assign o_frame_ready = bank_full_q[rd_bank_q];
  assign o_overflow    = overflow_q;
  assign o_frame_count = frame_count_q;
  assign o_data        = (o_frame_ready && in_range) ? mem[rd_bank_q][address[IW-1:0]] : '0;

endmodule

// File: tb/tb_maxpool_frame_buffer.sv
// Self-checking bench: 3x3 instance for table, corner-case and random checks,
// plus a default 55x55 instance for the full-size frame boundary.
module tb_maxpool_frame_buffer;

  localparam int FR = 9;
  localparam int BF = 3025;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] i_data = '0;
  logic        i_data_valid = 1'b0;
  logic        i_frame_release = 1'b0;
  logic [31:0] address = '0;
  logic        o_wr_ready, o_overflow, o_frame_ready;
  logic [15:0] o_data;
  logic [7:0]  o_frame_count;

  logic [15:0] b_data = '0;
  logic        b_valid = 1'b0;
  logic        b_release = 1'b0;
  logic [31:0] b_address = '0;
  logic        b_wr_ready, b_overflow, b_frame_ready;
  logic [15:0] b_odata;
  logic [7:0]  b_frame_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  maxpool_frame_buffer #(.datwidth(16), .outputsize(3), .addrwidth(4)) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_data_valid(i_data_valid),
    .o_wr_ready(o_wr_ready), .o_overflow(o_overflow), .address(address),
    .o_data(o_data), .o_frame_ready(o_frame_ready),
    .i_frame_release(i_frame_release), .o_frame_count(o_frame_count)
  );

  maxpool_frame_buffer u_big (
    .clk(clk), .rst(rst), .i_data(b_data), .i_data_valid(b_valid),
    .o_wr_ready(b_wr_ready), .o_overflow(b_overflow), .address(b_address),
    .o_data(b_odata), .o_frame_ready(b_frame_ready),
    .i_frame_release(b_release), .o_frame_count(b_frame_count)
  );

  // Reference model: queue of completed frames (oldest first) plus partial frame.
  int  full_q[$];
  int  part_q[$];
  bit  m_ovf;
  int  m_cnt;

  task automatic modelReset();
    full_q.delete();
    part_q.delete();
    m_ovf = 1'b0;
    m_cnt = 0;
  endtask

  task automatic modelUpdate(input bit v, input int d, input bit rel);
    int nf;
    bit acc, relok;
    nf    = full_q.size() / FR;
    acc   = v && (nf < 2);
    relok = rel && (nf > 0);
    if (v && !acc) m_ovf = 1'b1;
    if (relok) repeat (FR) void'(full_q.pop_front());
    if (acc) begin
      part_q.push_back(d);
      if (part_q.size() == FR) begin
        foreach (part_q[k]) full_q.push_back(part_q[k]);
        part_q.delete();
        m_cnt = (m_cnt + 1) % 256;
      end
    end
  endtask

  function automatic int modelData(input int a);
    if ((full_q.size() >= FR) && (a < FR)) return full_q[a];
    return 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit v, input int d, input bit rel, input int a);
    i_data          = 16'(d);
    i_data_valid    = v;
    i_frame_release = rel;
    address         = 32'(a);
    @(posedge clk);
    modelUpdate(v, d, rel);
    #1;
    i_data_valid    = 1'b0;
    i_frame_release = 1'b0;
  endtask

  task automatic peek(input string name, input int a, input int exp);
    address = 32'(a);
    #1;
    chk(name, int'(o_data), exp);
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, ".wr_ready"}, int'(o_wr_ready), int'((full_q.size() / FR) < 2));
    chk({tag, ".frame_ready"}, int'(o_frame_ready), int'(full_q.size() >= FR));
    chk({tag, ".overflow"}, int'(o_overflow), int'(m_ovf));
    chk({tag, ".frame_count"}, int'(o_frame_count), m_cnt);
    chk({tag, ".data"}, int'(o_data), modelData(int'(address)));
  endtask

  task automatic doReset();
    rst             = 1'b0;
    i_data_valid    = 1'b0;
    i_frame_release = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    modelReset();
  endtask

  typedef struct {
    bit v; int d; bit rel; int addr;
    bit fr; bit wr; int dat; int cnt;
  } vec_t;

  function automatic vec_t mk(bit v, int d, bit rel, int addr, bit fr, bit wr, int dat, int cnt);
    vec_t r;
    r.v = v; r.d = d; r.rel = rel; r.addr = addr;
    r.fr = fr; r.wr = wr; r.dat = dat; r.cnt = cnt;
    return r;
  endfunction

  vec_t tbl[14];

  initial begin
    tbl[0]  = mk(1, 1, 0, 0, 0, 1, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 1, 0, 0);
    tbl[2]  = mk(1, 2, 0, 0, 0, 1, 0, 0);
    tbl[3]  = mk(1, 3, 0, 0, 0, 1, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 1, 0, 0);
    tbl[5]  = mk(1, 4, 0, 0, 0, 1, 0, 0);
    tbl[6]  = mk(1, 5, 0, 0, 0, 1, 0, 0);
    tbl[7]  = mk(1, 6, 0, 0, 0, 1, 0, 0);
    tbl[8]  = mk(1, 7, 0, 0, 0, 1, 0, 0);
    tbl[9]  = mk(1, 8, 0, 0, 0, 1, 0, 0);
    tbl[10] = mk(1, 9, 0, 0, 1, 1, 1, 1);
    tbl[11] = mk(0, 0, 0, 8, 1, 1, 9, 1);
    tbl[12] = mk(0, 0, 0, 9, 1, 1, 0, 1);
    tbl[13] = mk(0, 0, 0, 4, 1, 1, 5, 1);

    modelReset();
    #2;
    doReset();
    chk("reset.wr_ready", int'(o_wr_ready), 1);
    chk("reset.frame_ready", int'(o_frame_ready), 0);
    chk("reset.overflow", int'(o_overflow), 0);
    chk("reset.frame_count", int'(o_frame_count), 0);
    chk("reset.data", int'(o_data), 0);

    // Test 1: first frame with gaps
    foreach (tbl[i]) begin
      applyStimulus(tbl[i].v, tbl[i].d, tbl[i].rel, tbl[i].addr);
      chk($sformatf("t1[%0d].frame_ready", i), int'(o_frame_ready), int'(tbl[i].fr));
      chk($sformatf("t1[%0d].wr_ready", i), int'(o_wr_ready), int'(tbl[i].wr));
      chk($sformatf("t1[%0d].data", i), int'(o_data), tbl[i].dat);
      chk($sformatf("t1[%0d].frame_count", i), int'(o_frame_count), tbl[i].cnt);
    end

    // Test 2: second frame while frame 1 is held
    for (int i = 0; i < FR; i++) begin
      applyStimulus(1, 11 + i, 0, 0);
      chk("t2.frame_ready", int'(o_frame_ready), 1);
      chk("t2.data", int'(o_data), 1);
    end
    chk("t2.frame_count", int'(o_frame_count), 2);
    chk("t3.wr_ready_full", int'(o_wr_ready), 0);

    // Test 3: drops while both banks full, release edge pixel also dropped
    applyStimulus(1, 99, 0, 0);
    chk("t3.overflow", int'(o_overflow), 1);
    chk("t3.frame_count_held", int'(o_frame_count), 2);
    applyStimulus(1, 98, 1, 0);
    chk("t2.release.frame_ready", int'(o_frame_ready), 1);
    chk("t2.release.data", int'(o_data), 11);
    chk("t3.wr_ready_freed", int'(o_wr_ready), 1);
    for (int i = 0; i < FR; i++) applyStimulus(1, 31 + i, 0, 0);
    chk("t3.frame_count", int'(o_frame_count), 3);
    chk("t3.wr_ready_refull", int'(o_wr_ready), 0);
    peek("t3.frame2_addr8", 8, 19);

    // Test 4: release bank0 on the same edge bank1 completes
    applyStimulus(0, 0, 1, 0);
    chk("t3.frame3_addr0", int'(o_data), 31);
    peek("t3.frame3_addr8", 8, 39);
    for (int i = 0; i < FR - 1; i++) applyStimulus(1, 41 + i, 0, 0);
    applyStimulus(1, 49, 1, 0);
    chk("t4.frame_ready", int'(o_frame_ready), 1);
    chk("t4.data_addr0", int'(o_data), 41);
    chk("t4.wr_ready", int'(o_wr_ready), 1);
    chk("t4.frame_count", int'(o_frame_count), 4);
    chk("t4.overflow_sticky", int'(o_overflow), 1);
    peek("t4.data_addr8", 8, 49);
    applyStimulus(0, 0, 1, 0);
    chk("t4.second_release", int'(o_frame_ready), 0);

    // Test 5: reset mid-frame
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1, 100 + i, 0, 0);
    doReset();
    chk("t5.reset.frame_ready", int'(o_frame_ready), 0);
    chk("t5.reset.overflow", int'(o_overflow), 0);
    chk("t5.reset.frame_count", int'(o_frame_count), 0);
    for (int i = 0; i < FR; i++) begin
      applyStimulus(1, 21 + i, 0, 0);
      chk($sformatf("t5.frame_ready[%0d]", i), int'(o_frame_ready), (i == FR - 1) ? 1 : 0);
    end
    chk("t5.data_addr0", int'(o_data), 21);
    chk("t5.frame_count", int'(o_frame_count), 1);
    chk("t5.overflow", int'(o_overflow), 0);

    // Randomized traffic against the frame-queue model
    doReset();
    for (int n = 0; n < 800; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 65535)),
                    ($urandom_range(0, 24) == 0), int'($urandom_range(0, 10)));
      checkOutput("rand");
    end

    // Test 6: default 55x55 instance
    b_release = 1'b1;
    @(posedge clk);
    #1;
    b_release = 1'b0;
    chk("t6.release_ignored.frame_ready", int'(b_frame_ready), 0);
    chk("t6.release_ignored.wr_ready", int'(b_wr_ready), 1);
    for (int i = 0; i < BF; i++) begin
      b_data  = 16'(i + 1);
      b_valid = 1'b1;
      @(posedge clk);
      #1;
      b_valid = 1'b0;
      if (i == BF - 2) chk("t6.frame_ready_at_3024", int'(b_frame_ready), 0);
    end
    chk("t6.frame_ready_at_3025", int'(b_frame_ready), 1);
    chk("t6.frame_count", int'(b_frame_count), 1);
    b_address = 32'd3024;
    #1;
    chk("t6.addr3024", int'(b_odata), 3025);
    b_address = 32'd3025;
    #1;
    chk("t6.addr3025", int'(b_odata), 0);
    b_address = 32'd0;
    #1;
    chk("t6.addr0", int'(b_odata), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
